// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - PUSH/POP multi-register sequencer: one data-memory access per listed register,
// register-file/PC writeback for POP, SP update on completion.
module stack_seq #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_pop,
  input  logic [NREG:0] rl,
  input  logic [AW-1:0] sp_in,
  input  logic [AW-1:0] lr_in,
  input  logic [DW-1:0] rf_rdata,
  input  logic [DW-1:0] dmem_rdata,
  output logic          busy,
  output logic          stall,
  output logic          done,
  output logic [2:0]    rf_raddr,
  output logic [2:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_wen,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_wr,
  output logic          dmem_req,
  output logic [AW-1:0] sp_out,
  output logic          sp_wen,
  output logic [AW-1:0] pc_out,
  output logic          pc_wen
);

  localparam int IW = $clog2(NREG + 1);
  localparam int CW = $clog2(NREG + 2);
  localparam logic [IW-1:0] LR_IDX = IW'(NREG);

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_POP_DRAIN, S_FIN} state_t;

  state_t        state, state_nx;
  logic [NREG:0] pend;
  logic [NREG:0] pend_rest;
  logic [AW-1:0] base;
  logic [CW-1:0] cnt;
  logic [CW-1:0] off;
  logic          pop_l;
  logic          wb_valid;
  logic [IW-1:0] wb_idx;
  logic [IW-1:0] low_idx;
  logic [CW-1:0] rl_cnt;

  // Lowest pending register is the next one transferred; clearing it leaves the rest.
  always_comb begin
    low_idx = '0;
    for (int i = NREG; i >= 0; i--) begin
      if (pend[i]) low_idx = IW'(i);
    end
  end

  assign pend_rest = pend & (pend - 1'b1);

  always_comb begin
    rl_cnt = '0;
    for (int i = 0; i <= NREG; i++) begin
      rl_cnt = rl_cnt + CW'(rl[i]);
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = busy | (start & ~busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    done       = 1'b0;
    rf_raddr   = '0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    rf_wen     = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wr    = 1'b0;
    dmem_req   = 1'b0;
    sp_out     = '0;
    sp_wen     = 1'b0;
    pc_out     = '0;
    pc_wen     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (rl == '0)  state_nx = S_FIN;
          else if (is_pop) state_nx = S_POP;
          else           state_nx = S_PUSH;
        end
      end
      S_PUSH: begin
        dmem_req  = 1'b1;
        dmem_wr   = 1'b1;
        dmem_addr = base + AW'(off);
        if (low_idx != LR_IDX) begin
          rf_raddr   = low_idx[2:0];
          dmem_wdata = rf_rdata;
        end else begin
          dmem_wdata = {{(DW-AW){1'b0}}, lr_in};
        end
        if (pend_rest == '0) state_nx = S_FIN;
      end
      S_POP: begin
        dmem_req  = 1'b1;
        dmem_addr = base + AW'(off);
        if (pend_rest == '0) state_nx = S_POP_DRAIN;
      end
      S_POP_DRAIN: state_nx = S_FIN;
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
        if (cnt != '0) begin
          sp_wen = 1'b1;
          sp_out = pop_l ? base + AW'(cnt) : base;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Load data arrives one cycle after its issue, so writeback trails the read stream.
    if (wb_valid) begin
      if (wb_idx != LR_IDX) begin
        rf_wen   = 1'b1;
        rf_waddr = wb_idx[2:0];
        rf_wdata = dmem_rdata;
      end else begin
        pc_wen = 1'b1;
        pc_out = dmem_rdata[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      base     <= '0;
      cnt      <= '0;
      off      <= '0;
      pop_l    <= 1'b0;
      wb_valid <= 1'b0;
      wb_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pend     <= rl;
            pop_l    <= is_pop;
            cnt      <= rl_cnt;
            base     <= is_pop ? sp_in : sp_in - AW'(rl_cnt);
            off      <= '0;
            wb_valid <= 1'b0;
          end
        end
        S_PUSH: begin
          pend <= pend_rest;
          off  <= off + CW'(1);
        end
        S_POP: begin
          pend     <= pend_rest;
          off      <= off + CW'(1);
          wb_valid <= 1'b1;
          wb_idx   <= low_idx;
        end
        S_POP_DRAIN: wb_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - scoreboard bench for stack_seq: memory/RF environment, reference stack model,
// expected accesses queued per channel with their cycle numbers.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_pop;
  logic [8:0]  rl;
  logic [15:0] sp_in;
  logic [15:0] lr_in;
  logic [31:0] rf_rdata;
  logic [31:0] dmem_rdata;
  logic        busy, stall, done;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_wr, dmem_req;
  logic [15:0] sp_out;
  logic        sp_wen;
  logic [15:0] pc_out;
  logic        pc_wen;

  stack_seq #(.DW(32), .AW(16), .NREG(8)) dut (
    .clk(clk), .reset(reset), .start(start), .is_pop(is_pop), .rl(rl),
    .sp_in(sp_in), .lr_in(lr_in), .rf_rdata(rf_rdata), .dmem_rdata(dmem_rdata),
    .busy(busy), .stall(stall), .done(done), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wen(rf_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wr(dmem_wr), .dmem_req(dmem_req), .sp_out(sp_out), .sp_wen(sp_wen),
    .pc_out(pc_out), .pc_wen(pc_wen)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [15:0] addr; logic [31:0] data; logic wr;} mem_ev_t;
  typedef struct {int cyc; logic [2:0] idx; logic [31:0] data;} rf_ev_t;
  typedef struct {int cyc; logic [15:0] pc;} pc_ev_t;
  typedef struct {int cyc; logic spw; logic [15:0] sp;} done_ev_t;

  mem_ev_t  mem_q[$];
  rf_ev_t   rf_q[$];
  pc_ev_t   pc_q[$];
  done_ev_t done_q[$];

  logic [31:0] env_mem [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic [31:0] env_rf  [0:7];
  logic [31:0] ref_rf  [0:7];
  logic [31:0] rd_q;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rdata   = env_rf[rf_raddr];
  assign dmem_rdata = rd_q;

  always @(posedge clk) begin
    if (dmem_req && dmem_wr) env_mem[dmem_addr] = dmem_wdata;
    if (rf_wen) env_rf[rf_waddr] = rf_wdata;
    if (dmem_req && !dmem_wr) rd_q <= env_mem[dmem_addr];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic stray(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=unexpected required=none (cycle %0d)", nm, cyc);
  endtask

  mem_ev_t  me;
  rf_ev_t   re;
  pc_ev_t   pe;
  done_ev_t de;

  always @(negedge clk) begin
    if (!reset) begin
      if (dmem_req) begin
        if (mem_q.size() == 0) stray("mem_access");
        else begin
          me = mem_q.pop_front();
          chk("mem_cyc", cyc, me.cyc);
          chk("mem_addr", dmem_addr, me.addr);
          chk("mem_wr", dmem_wr, me.wr);
          if (me.wr) chk("mem_wdata", dmem_wdata, me.data);
        end
      end
      if (rf_wen) begin
        if (rf_q.size() == 0) stray("rf_write");
        else begin
          re = rf_q.pop_front();
          chk("rf_cyc", cyc, re.cyc);
          chk("rf_waddr", rf_waddr, re.idx);
          chk("rf_wdata", rf_wdata, re.data);
        end
      end
      if (pc_wen) begin
        if (pc_q.size() == 0) stray("pc_write");
        else begin
          pe = pc_q.pop_front();
          chk("pc_cyc", cyc, pe.cyc);
          chk("pc_out", pc_out, pe.pc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) stray("done");
        else begin
          de = done_q.pop_front();
          chk("done_cyc", cyc, de.cyc);
          chk("sp_wen", sp_wen, de.spw);
          if (de.spw) chk("sp_out", sp_out, de.sp);
        end
      end else if (sp_wen) stray("sp_wen_without_done");
    end
  end

  // Reference: full-descending stack, ascending register order, lowest register at lowest address.
  task automatic model_op(input int c, input bit pop, input logic [8:0] list,
                          input logic [15:0] sp, input logic [15:0] lr);
    int n;
    int k;
    logic [15:0] base;
    logic [15:0] a;
    logic [31:0] d;
    n = $countones(list);
    if (n == 0) begin
      done_q.push_back('{c + 1, 1'b0, 16'h0});
      return;
    end
    base = pop ? sp : sp - 16'(n);
    k = 0;
    for (int i = 0; i <= 8; i++) begin
      if (list[i]) begin
        a = base + 16'(k);
        if (!pop) begin
          d = (i < 8) ? ref_rf[i] : {16'h0, lr};
          ref_mem[a] = d;
          mem_q.push_back('{c + 1 + k, a, d, 1'b1});
        end else begin
          d = ref_mem[a];
          mem_q.push_back('{c + 1 + k, a, 32'h0, 1'b0});
          if (i < 8) begin
            ref_rf[i] = d;
            rf_q.push_back('{c + 2 + k, 3'(i), d});
          end else begin
            pc_q.push_back('{c + 2 + k, d[15:0]});
          end
        end
        k++;
      end
    end
    if (pop) done_q.push_back('{c + n + 2, 1'b1, sp + 16'(n)});
    else     done_q.push_back('{c + n + 1, 1'b1, base});
  endtask

  task automatic do_op(input bit pop, input logic [8:0] list, input logic [15:0] sp,
                       input logic [15:0] lr, input bit dup);
    int t;
    @(negedge clk);
    is_pop = pop;
    rl     = list;
    sp_in  = sp;
    lr_in  = lr;
    start  = 1'b1;
    model_op(cyc, pop, list, sp, lr);
    if (dup) begin
      #1 chk("stall_cycle0", stall, 1'b1);
    end
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      if (dup && t == 2) begin
        start  = 1'b1;
        rl     = 9'h0FF;
        is_pop = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (dup) begin
        #1 chk("stall_hold", stall, 1'b1);
      end
      if (done) break;
      if (t > 40) begin
        stray("done_timeout");
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {busy, stall, done, rf_raddr, rf_waddr, rf_wdata, rf_wen, dmem_addr, dmem_wdata,
             dmem_wr, dmem_req, sp_out, sp_wen, pc_out, pc_wen}, '0);
  endtask

  initial begin
    int nmis;
    reset  = 1'b1;
    start  = 1'b0;
    is_pop = 1'b0;
    rl     = '0;
    sp_in  = '0;
    lr_in  = '0;
    rd_q   = '0;
    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      env_rf[i] = $urandom;
      ref_rf[i] = env_rf[i];
    end
    env_rf[0] = 32'h11; ref_rf[0] = 32'h11;
    env_rf[2] = 32'h22; ref_rf[2] = 32'h22;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    reset = 1'b0;

    do_op(1'b0, 9'h105, 16'h0100, 16'h0040, 1'b0);
    env_mem[16'h00FD] = 32'hAAAA5555; ref_mem[16'h00FD] = 32'hAAAA5555;
    env_mem[16'h00FE] = 32'h00001234; ref_mem[16'h00FE] = 32'h00001234;
    do_op(1'b1, 9'h102, 16'h00FD, 16'h0000, 1'b0);
    do_op(1'b0, 9'h000, 16'h0200, 16'h0000, 1'b0);
    do_op(1'b1, 9'h000, 16'h0200, 16'h0000, 1'b0);
    do_op(1'b0, 9'h007, 16'h0001, 16'h0000, 1'b0);
    do_op(1'b1, 9'h1FF, 16'hFFFC, 16'h0000, 1'b0);
    do_op(1'b0, 9'h007, 16'h0300, 16'h0000, 1'b1);

    // Abort a PUSH after its first store: that store stays, nothing else happens.
    @(negedge clk);
    is_pop = 1'b0;
    rl     = 9'h105;
    sp_in  = 16'h0100;
    lr_in  = 16'h0040;
    start  = 1'b1;
    mem_q.push_back('{cyc + 1, 16'h00FD, ref_rf[0], 1'b1});
    ref_mem[16'h00FD] = ref_rf[0];
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_outputs_zero("reset_midseq_outputs");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_leftover_mem", mem_q.size(), 0);
    do_op(1'b0, 9'h105, 16'h0100, 16'h0040, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [8:0] l;
      l = ($urandom_range(0, 9) == 0) ? 9'h0 : 9'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(1'($urandom), l, 16'($urandom), 16'($urandom), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("leftover_mem", mem_q.size(), 0);
    chk("leftover_rf", rf_q.size(), 0);
    chk("leftover_pc", pc_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);
    for (int i = 0; i < 8; i++) chk("rf_final", env_rf[i], ref_rf[i]);
    nmis = 0;
    for (int i = 0; i < 65536; i++) if (env_mem[i] !== ref_mem[i]) nmis++;
    chk("mem_final_mismatches", nmis, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
